// File: rtl/lynx_video_pkg.sv
`default_nettype none
// ============================================================================
// lynx_video_pkg
// Shared widths and state encodings for the Lynx 48 video RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package lynx_video_pkg;

  localparam int VRAM_AW = 15;  // {bank, addr} into the 32 KB video RAM
  localparam int BANK_W  = 2;   // four 8 KB banks
  localparam int ADDR_W  = 13;  // byte address within one bank

  // Arbiter sequencer: one idle state, then issue/data pairs per client.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_V_ISSUE = 3'd1,
    ST_V_DATA  = 3'd2,
    ST_C_ISSUE = 3'd3,
    ST_C_DATA  = 3'd4
  } arb_state_t;

  // Which client owns the slot on the current ce.
  typedef enum logic {
    SLOT_VIDEO = 1'b0,
    SLOT_CPU   = 1'b1
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// vram_arbiter_if
// Z80 side of the video RAM arbiter: request/ack handshake plus WAIT_n.
// Revision: 1.0 - initial release
// ============================================================================
interface vram_arbiter_if;
  import lynx_video_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [BANK_W-1:0] cpu_bank;
  logic [ADDR_W-1:0] cpu_a;
  logic [7:0]        cpu_di;
  logic [7:0]        cpu_do;
  logic              cpu_ack;
  logic              cpu_wait_n;

  // CPU bus interface unit drives requests
  modport master (
    output cpu_req, cpu_we, cpu_bank, cpu_a, cpu_di,
    input  cpu_do, cpu_ack, cpu_wait_n
  );

  // Arbiter answers them
  modport slave (
    input  cpu_req, cpu_we, cpu_bank, cpu_a, cpu_di,
    output cpu_do, cpu_ack, cpu_wait_n
  );

endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// vram_arbiter
// Time-slices the single-port video RAM between the video fetch and the Z80.
// Video owns alternate ce slots during active display; the CPU gets the rest
// and every slot during blanking. Slot phase realigns on each hsync rise.
// Revision: 1.0 - initial release
// ============================================================================
module vram_arbiter
  import lynx_video_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic                hsync,
  input  logic                blank,
  input  logic [ADDR_W-1:0]   va,
  input  logic [BANK_W-1:0]   vb,
  output logic [7:0]          vd,
  vram_arbiter_if.slave       cpu,
  output logic [VRAM_AW-1:0]  ram_a,
  output logic                ram_we,
  output logic [7:0]          ram_d,
  input  logic [7:0]          ram_q
);

  arb_state_t state;
  arb_state_t state_next;
  slot_t      phase;
  logic       hsync_d;
  logic       ack_done;
  logic       access_we;
  logic [7:0] cpu_do_q;
  logic       cpu_ack_q;

  logic hsync_rise;
  logic video_slot;
  logic cpu_pending;
  logic grant_video;
  logic grant_cpu;

  assign hsync_rise  = hsync & ~hsync_d;
  // The ce that sees hsync rise is always a video slot, whatever phase says.
  assign video_slot  = hsync_rise | (phase == SLOT_VIDEO);
  assign cpu_pending = cpu.cpu_req & ~ack_done;
  assign grant_video = ce & (state == ST_IDLE) & video_slot & ~blank;
  assign grant_cpu   = ce & (state == ST_IDLE) & ~(video_slot & ~blank) & cpu_pending;

  assign cpu.cpu_do     = cpu_do_q;
  assign cpu.cpu_ack    = cpu_ack_q;
  assign cpu.cpu_wait_n = ~cpu_pending;

  // Slot phase: alternate on every ce, forced back into step by hsync rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase   <= SLOT_VIDEO;
      hsync_d <= 1'b0;
    end else if (ce) begin
      hsync_d <= hsync;
      phase   <= video_slot ? SLOT_CPU : SLOT_VIDEO;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: every access is issue, data, back to idle.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (grant_video) begin
          state_next = ST_V_ISSUE;
        end else if (grant_cpu) begin
          state_next = ST_C_ISSUE;
        end
      end
      ST_V_ISSUE: state_next = ST_V_DATA;
      ST_V_DATA:  state_next = ST_IDLE;
      ST_C_ISSUE: state_next = ST_C_DATA;
      ST_C_DATA:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // RAM command and returned-data registers. The ack is registered on the
  // C_DATA exit so cpu_do is already valid in the same clock as the ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_a     <= '0;
      ram_d     <= '0;
      ram_we    <= 1'b0;
      vd        <= '0;
      cpu_do_q  <= '0;
      cpu_ack_q <= 1'b0;
      access_we <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      cpu_ack_q <= 1'b0;
      if (grant_video) begin
        ram_a <= {vb, va};
      end else if (grant_cpu) begin
        ram_a     <= {cpu.cpu_bank, cpu.cpu_a};
        ram_d     <= cpu.cpu_di;
        ram_we    <= cpu.cpu_we;
        access_we <= cpu.cpu_we;
      end
      if (state == ST_V_DATA) begin
        vd <= ram_q;
      end
      if (state == ST_C_DATA) begin
        cpu_ack_q <= 1'b1;
        if (!access_we) begin
          cpu_do_q <= ram_q;
        end
      end
    end
  end

  // Remembers that the current request was served until the CPU drops it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_done <= 1'b0;
    end else if (state == ST_C_DATA) begin
      ack_done <= 1'b1;
    end else if (!cpu.cpu_req) begin
      ack_done <= 1'b0;
    end
  end

  // A ce arriving mid-access means the ce spacing contract was broken.
  a_ce_only_when_idle: assert property (@(posedge clock) disable iff (reset)
    ce |-> (state == ST_IDLE));

  // The sequencer timing assumes a one-clock synchronous RAM.
  a_ram_latency: assert property (@(posedge clock) RAM_LAT == 1);

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vram_arbiter
// Randomized bench for vram_arbiter with a slot-schedule reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;
  import lynx_video_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce    = 1'b0;
  logic        hsync = 1'b0;
  logic        blank = 1'b0;
  logic [12:0] va    = '0;
  logic [1:0]  vb    = '0;
  logic [7:0]  vd;
  logic [14:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;

  vram_arbiter_if cpu ();

  vram_arbiter #(.RAM_LAT(1)) dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .hsync  (hsync),
    .blank  (blank),
    .va     (va),
    .vb     (vb),
    .vd     (vd),
    .cpu    (cpu.slave),
    .ram_a  (ram_a),
    .ram_we (ram_we),
    .ram_d  (ram_d),
    .ram_q  (ram_q)
  );

  always #5 clock = ~clock;

  // Physical video RAM: synchronous, one clock read latency.
  logic [7:0] ram     [0:32767];
  logic [7:0] ref_mem [0:32767];
  always @(posedge clock) begin
    if (ram_we) ram[ram_a] <= ram_d;
    ram_q <= ram[ram_a];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model state: slot schedule and the one access in flight.
  int          align_cnt;
  bit          prev_hsync;
  int          ev_kind;      // 0 none, 1 video, 2 cpu
  int          ev_cyc;       // edge index at which the access was granted
  logic [14:0] ev_addr;
  bit          ev_we;
  logic [7:0]  ev_data;
  logic [7:0]  ev_val;
  logic [7:0]  m_vd, m_do, m_ram_d;
  logic [14:0] m_ram_a;
  bit          m_we, m_ack;
  int          can_req_at;
  int          since_ce, gap;
  bit          first_ce, is_edge, video_slot;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[15'h2345] = 8'hA5; ref_mem[15'h2345] = 8'hA5;
    ram[15'h4010] = 8'h3C; ref_mem[15'h4010] = 8'h3C;
    cpu.cpu_req = 1'b0; cpu.cpu_we = 1'b0; cpu.cpu_bank = '0;
    cpu.cpu_a = '0; cpu.cpu_di = '0;

    // Reset values
    repeat (3) @(negedge clock);
    check_eq("rst_vd",     vd,             0);
    check_eq("rst_cpu_do", cpu.cpu_do,     0);
    check_eq("rst_ack",    cpu.cpu_ack,    0);
    check_eq("rst_ram_we", ram_we,         0);
    check_eq("rst_ram_a",  ram_a,          0);
    check_eq("rst_ram_d",  ram_d,          0);
    check_eq("rst_wait_n", cpu.cpu_wait_n, 1);

    // Reset landing while a CPU write is in its issue clock
    reset = 1'b0; blank = 1'b1; ce = 1'b1;
    cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b1; cpu.cpu_bank = 2'd2;
    cpu.cpu_a = 13'h0010; cpu.cpu_di = 8'h3C;
    @(negedge clock);
    ce = 1'b0;
    check_eq("wr_ram_we",  ram_we,         1);
    check_eq("wr_ram_a",   ram_a,          15'h4010);
    check_eq("wr_ram_d",   ram_d,          8'h3C);
    check_eq("wr_wait_n",  cpu.cpu_wait_n, 0);
    reset = 1'b1;
    @(negedge clock);
    check_eq("cut_ram_we", ram_we,         0);
    check_eq("cut_ack",    cpu.cpu_ack,    0);
    check_eq("cut_vd",     vd,             0);
    check_eq("cut_ram_a",  ram_a,          0);
    check_eq("cut_wait_n", cpu.cpu_wait_n, 0);
    cpu.cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("cut_ack_hold", cpu.cpu_ack, 0);
    end
    check_eq("cut_wait_n_idle", cpu.cpu_wait_n, 1);
    reset = 1'b0; blank = 1'b0;

    align_cnt = 0; prev_hsync = 1'b0; ev_kind = 0; ev_cyc = 0;
    ev_addr = '0; ev_we = 1'b0; ev_data = '0; ev_val = '0;
    m_vd = '0; m_do = '0; m_ram_d = '0; m_ram_a = '0;
    can_req_at = 0; since_ce = 3; gap = 4; first_ce = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      // Model outputs after the edge that just happened
      if (ev_kind != 0 && cyc == ev_cyc) begin
        m_ram_a = ev_addr;
        if (ev_kind == 2) m_ram_d = ev_data;
      end
      m_we  = (ev_kind == 2) && (cyc == ev_cyc) && ev_we;
      m_ack = (ev_kind == 2) && (cyc == ev_cyc + 2);
      if (ev_kind != 0 && cyc == ev_cyc + 2) begin
        if (ev_kind == 1) m_vd = ev_val;
        else if (!ev_we)  m_do = ev_val;
        ev_kind = 0;
      end

      check_eq("vd",     vd,             m_vd);
      check_eq("cpu_do", cpu.cpu_do,     m_do);
      check_eq("ack",    cpu.cpu_ack,    m_ack);
      check_eq("ram_we", ram_we,         m_we);
      check_eq("ram_a",  ram_a,          m_ram_a);
      check_eq("ram_d",  ram_d,          m_ram_d);
      check_eq("wait_n", cpu.cpu_wait_n, !(cpu.cpu_req && !m_ack));

      // CPU agent: drop after ack, sometimes abandon, sometimes start new
      ce = 1'b0;
      since_ce++;
      if (m_ack) begin
        cpu.cpu_req = 1'b0; can_req_at = cyc + 1;
      end else if (cpu.cpu_req && ev_kind != 2 && $urandom_range(0, 15) == 0) begin
        cpu.cpu_req = 1'b0; can_req_at = cyc + 1;
      end else if (!cpu.cpu_req && ev_kind != 2 && cyc >= can_req_at &&
                   $urandom_range(0, 3) == 0) begin
        cpu.cpu_req  = 1'b1;
        cpu.cpu_we   = ($urandom_range(0, 2) == 0);
        cpu.cpu_bank = 2'($urandom);
        cpu.cpu_a    = 13'($urandom);
        cpu.cpu_di   = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) hsync = ~hsync;

      if (since_ce >= gap) begin
        ce = 1'b1; since_ce = 0; gap = $urandom_range(4, 6);
        blank = ($urandom_range(0, 2) == 0);
        va = 13'($urandom); vb = 2'($urandom);
        if (first_ce) begin
          va = 13'h0345; vb = 2'd1; blank = 1'b0; hsync = 1'b0; first_ce = 1'b0;
        end
        // Slot schedule: even ce count since the last realign is video.
        is_edge    = hsync && !prev_hsync;
        prev_hsync = hsync;
        video_slot = is_edge || (align_cnt % 2 == 0);
        align_cnt  = is_edge ? 1 : align_cnt + 1;
        if (video_slot && !blank) begin
          ev_kind = 1; ev_cyc = cyc + 1; ev_addr = {vb, va};
          ev_val  = ref_mem[{vb, va}];
        end else if (cpu.cpu_req) begin
          ev_kind = 2; ev_cyc = cyc + 1;
          ev_addr = {cpu.cpu_bank, cpu.cpu_a};
          ev_we   = cpu.cpu_we; ev_data = cpu.cpu_di;
          ev_val  = ref_mem[ev_addr];
          if (ev_we) ref_mem[ev_addr] = ev_data;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sits directly upstream of the Lynx 48 video generator.
- Owns the single-port 32 KB video RAM (four 8 KB banks) and time-slices it between two clients:
  - Video fetch: 13-bit address plus 2-bit bank from the video generator. The returned byte feeds the generator's data input.
  - Z80 accesses to video memory.
- Video has fixed slots during active display. The CPU gets the remaining slots, and all slots during blanking, with Z80 wait generation.

Parameters:
- RAM_LAT, 1, synchronous RAM read latency in clocks. Only 1 is supported; kept as a parameter for documentation and assertions.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  pixel clock enable, same strobe the video generator uses; at least 4 clocks apart
- hsync  in  1  video generator hSync, used for slot phase alignment
- blank  in  1  video generator hBlank|vBlank; 1 releases video slots to CPU
- va  in  13  video address {vCount[7:0],hCount[7:3]}
- vb  in  2  video bank select
- vd  out  8  video data, held stable between fetches
- cpu_req  in  1  CPU video-memory request, held until acknowledged
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_bank  in  2  CPU bank select
- cpu_a  in  13  CPU address
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data, valid while cpu_ack
- cpu_ack  out  1  single-clock completion pulse
- cpu_wait_n  out  1  Z80 WAIT_n; 0 while a request is pending and not yet acked
- ram_a  out  15  {bank,addr}
- ram_we  out  1  RAM write strobe, one clock
- ram_d  out  8  RAM write data
- ram_q  in  8  RAM read data, valid RAM_LAT clocks after address

Behaviour:
- Reset values:
  - vd=0, cpu_do=0, cpu_ack=0, ram_we=0, ram_a=0, ram_d=0.
  - Phase=VIDEO, FSM=IDLE, hsync_d=0.
- cpu_wait_n = !(cpu_req && !ack_done), where ack_done is set by cpu_ack and cleared when cpu_req drops. During reset cpu_wait_n follows cpu_req, with ack_done=0.
- Slot phase:
  - The phase bit toggles on every ce.
  - On a ce where hsync=1 and hsync_d=0, that ce is forced to a VIDEO slot and phase becomes CPU for the next ce. hsync_d updates only on ce.
- Slot grant, evaluated on each ce cycle with FSM=IDLE:
  - VIDEO slot and blank=0 → start video fetch.
  - VIDEO slot and blank=1, or CPU slot → start CPU access if cpu_req && !ack_done, else stay idle.
- FSM states: IDLE, V_ISSUE, V_DATA, C_ISSUE, C_DATA.
  - IDLE→V_ISSUE: ram_a<={vb,va} registered; ram_we=0.
  - V_ISSUE→V_DATA: after one clock.
  - V_DATA: vd<=ram_q, then →IDLE.
  - IDLE→C_ISSUE: ram_a<={cpu_bank,cpu_a}, ram_d<=cpu_di, ram_we<=cpu_we.
  - C_ISSUE→C_DATA: ram_we returns to 0, so it is exactly one clock wide.
  - C_DATA: if read, cpu_do<=ram_q. cpu_ack=1 for this one clock, ack_done<=1, then →IDLE.
- Latency:
  - Video: vd is updated 3 clocks after the granting ce. It is therefore stable before the next ce, when the generator samples it.
  - CPU: ack arrives at most 2 ce periods plus 3 clocks after the request.
- Boundaries:
  - A ce that arrives while FSM≠IDLE is ignored for granting but still toggles the phase. This is illegal given the ce spacing rule; flag it with an assertion.
  - cpu_req dropping before ack: an access already in C_ISSUE/C_DATA completes without harm. A pending request that is not yet granted is abandoned.
  - Simultaneous CPU request and video slot with blank=0: video wins and the CPU waits.
  - Reset mid-access returns to IDLE. The ram_we pulse is cut off on the reset clock.
  - vd holds its value across blanking.

Decomposition:
- Shared package lynx_video_pkg:
  - FSM state enum.
  - Constants VRAM_AW=15, BANK_W=2, ADDR_W=13.
- No sub-module. The slot-phase/hsync-edge logic is a small always block inside vram_arbiter.

Test Plan:
- Video fetch: preload RAM[0x2345]=0xA5 (bank1, addr 0x0345). Drive va=0x0345, vb=1, blank=0 on a VIDEO ce → vd=0xA5 exactly 3 clocks later; cpu_wait_n unaffected.
- CPU write in CPU slot: cpu_req=1, cpu_we=1, bank=2, addr=0x0010, di=0x3C → ram_we high for one clock with ram_a=0x4010. Then cpu_ack pulses, cpu_wait_n goes 0 → 1, and RAM[0x4010]=0x3C.
- Contention: cpu_req asserted on the clock before a VIDEO ce with blank=0 → video fetch first. The CPU is served on the next ce (CPU slot) and cpu_wait_n stays 0 in between.
- Blank release: blank=1, two back-to-back CPU reads of 0x0001 and 0x0002 (values 0x11, 0x22) → each is granted on consecutive ce with no video access, and cpu_do=0x11 then 0x22.
- Phase realign: deliberately misalign the phase, then raise hsync → the ce seeing the rising edge performs a video fetch and the following ce is a CPU slot.
- Reset mid-write: assert reset during C_ISSUE → ram_we=0 next clock, cpu_ack never pulses, FSM=IDLE, vd=0.
